fix_to_float: RTL and testbench
===============================

FIX_TO_FLOAT -- requirements
Module: fix_to_float

Interface
REQ-001 SHALL have parameter IW, default 8, integer bits of input including sign.
REQ-002 SHALL have parameter FW, default 8, fraction bits of input; W = IW+FW.
REQ-003 SHALL have parameter EW, default 5, output exponent width; BIAS = 2^(EW-1)-1.
REQ-004 SHALL have parameter MW, default 10, output mantissa width; requires MW <= W-2.
REQ-005 SHALL have parameter SIGNED, default 1, where 1 means two's-complement input and 0 means unsigned input.
REQ-006 SHALL have parameter ROUND, default 0, where 0 means truncate and 1 means round-to-nearest-even.
REQ-007 SHALL fail elaboration unless BIAS-FW >= 1 and W-FW+BIAS <= 2^EW-2 (no subnormal/inf outputs).
REQ-008 SHALL have port clk, input, 1 bit, single clock; all state updates on its rising edge.
REQ-009 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-010 SHALL have port start, input, 1 bit, request a new conversion.
REQ-011 SHALL have port din, input, W bits, fixed-point operand sampled on an accepted start.
REQ-012 SHALL have port dout, output, 1+EW+MW bits, result {sign, biased exponent, mantissa}.
REQ-013 SHALL have port busy, output, 1 bit, high while a conversion is in progress.
REQ-014 SHALL have port done, output, 1 bit, high while dout holds a valid result.

Function
REQ-015 SHALL implement an FSM with states IDLE, ABS, NORM, PACK, DONE.
REQ-016 SHALL accept start only in IDLE or DONE; on acceptance it latches din, clears done, sets busy, and enters ABS.
REQ-017 SHALL ignore start in ABS, NORM, or PACK, leaving the operand and the sequence undisturbed.
REQ-018 SHALL, in ABS, set sign = din[W-1] if SIGNED else 0; mag = |din| as W-bit unsigned, so 2^(W-1) is representable; exp = W-1-FW+BIAS.
REQ-019 SHALL, in ABS, go to PACK with a zero flag if mag == 0; otherwise it goes to NORM.
REQ-020 SHALL, in NORM, on each edge: if mag[W-1] == 0, shift mag left 1 and decrement exp by 1; otherwise go to PACK.
REQ-021 SHALL, in PACK, form mantissa = mag[W-2 : W-1-MW], guard = mag[W-2-MW], and sticky = OR of remaining lower bits.
REQ-022 SHALL, in PACK with ROUND = 1, add 1 to the mantissa when guard & (sticky | mantissa[0]); on mantissa carry-out the mantissa becomes 0 and exp increments.
REQ-023 SHALL, in PACK, write dout = {sign, exp, mantissa}, or all zeros when the zero flag is set (sign forced 0); then enter DONE with done = 1 and busy = 0.
REQ-024 SHALL, with k = leading zeros of mag, assert done on edge k+3 after the accepting edge; for zero input, done asserts on edge 2.
REQ-025 SHALL hold dout and done stable in DONE until the next accepted start.
REQ-026 SHALL, when reset and start coincide, give reset priority.

Reset
REQ-027 SHALL, on reset, go to IDLE with dout = 0, done = 0, busy = 0, and internal mag/exp/sign cleared, regardless of current state, including mid-NORM.
REQ-028 SHALL NOT produce a done pulse or dout update from an aborted conversion after reset.

Verification (defaults: IW=8, FW=8, EW=5, MW=10, SIGNED=1)
REQ-029 SHALL be verified by: din=0x0100, start -> dout=0x3C00; done on edge 10 (k=7); busy high edges 0..9.
REQ-030 SHALL be verified by: din=0x0000 -> dout=0x0000, done on edge 2; din=0x8000 -> dout=0xD800; din=0xFF80 -> dout=0xB800.
REQ-031 SHALL be verified by: din=0x7FFF with ROUND=0 -> dout=0x57FF; with ROUND=1 -> dout=0x5800 (mantissa carry into exponent).
REQ-032 SHALL be verified by: start pulsed again while busy with a different din -> result reflects the first operand only, and done timing is unchanged.
REQ-033 SHALL be verified by: reset asserted during NORM -> next edge done=0, busy=0, dout=0; a following conversion of 0x0100 is still correct.
REQ-034 SHALL be verified by: SIGNED=0 with din=0xFFFF -> sign 0, exp 22; ROUND=1 gives dout=0x5C00.

Source files
------------

// File: rtl/fix_to_float.sv
// Fixed-point to floating-point converter.
// A sequential converter: it takes the absolute value of the operand,
// normalises it one bit per clock, then packs sign, biased exponent and
// mantissa. Rounding is optional, to nearest with ties going to even.
module fix_to_float #(
    parameter int IW     = 8,
    parameter int FW     = 8,
    parameter int EW     = 5,
    parameter int MW     = 10,
    parameter int SIGNED = 1,
    parameter int ROUND  = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [IW+FW-1:0]   din,
    output logic [EW+MW:0]     dout,
    output logic               busy,
    output logic               done
);

    localparam int W    = IW + FW;
    localparam int BIAS = 2 ** (EW - 1) - 1;
    // Exponent of an operand whose top bit is set, before normalisation.
    localparam logic [EW-1:0] EXP_INIT = EW'(W - 1 - FW + BIAS);

    // Refuse parameter sets that could need subnormal or infinite results,
    // or that leave no room for a guard bit below the mantissa.
    if ((BIAS - FW) < 1 || (W - FW + BIAS) > (2 ** EW - 2) || MW > (W - 2)) begin : g_param_check
        $error("fix_to_float: unsupported parameter combination");
    end

    typedef enum logic [2:0] {IDLE, ABS, NORM, PACK, DONE} state_t;

    state_t          state;
    state_t          next_state;
    logic [W-1:0]    operand;
    logic [W-1:0]    mag;
    logic [EW-1:0]   exp_q;
    logic            sign;
    logic            zero;

    logic [MW-1:0]   mant;
    logic            guard;
    logic [W-1:0]    low_bits;
    logic            sticky;
    logic            round_up;
    logic [MW:0]     mant_rnd;
    logic [EW-1:0]   exp_final;

    // State register; reset always wins over a coincident start.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Sequencing: start is honoured only when no conversion is in flight.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = ABS;
            ABS:     next_state = (operand == '0) ? PACK : NORM;
            NORM:    if (mag[W-1]) next_state = PACK;
            PACK:    next_state = DONE;
            DONE:    if (start) next_state = ABS;
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state == ABS) || (state == NORM) || (state == PACK);
    assign done = (state == DONE);

    // Mantissa extraction and rounding from the normalised magnitude;
    // a carry out of the mantissa bumps the exponent and leaves zeros behind.
    always_comb begin
        mant      = mag[W-2 -: MW];
        guard     = mag[W-2-MW];
        low_bits  = mag << (MW + 2);
        sticky    = |low_bits;
        round_up  = (ROUND != 0) && guard && (sticky || mant[0]);
        mant_rnd  = {1'b0, mant} + {{MW{1'b0}}, round_up};
        exp_final = exp_q + {{(EW-1){1'b0}}, mant_rnd[MW]};
    end

    // Datapath: latch operand, take magnitude, normalise, then pack the result.
    always_ff @(posedge clk) begin
        if (reset) begin
            operand <= '0;
            mag     <= '0;
            exp_q   <= '0;
            sign    <= 1'b0;
            zero    <= 1'b0;
            dout    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) operand <= din;
                end
                ABS: begin
                    sign  <= (SIGNED != 0) ? operand[W-1] : 1'b0;
                    mag   <= ((SIGNED != 0) && operand[W-1]) ? -operand : operand;
                    exp_q <= EXP_INIT;
                    zero  <= (operand == '0);
                end
                NORM: begin
                    if (!mag[W-1]) begin
                        mag   <= mag << 1;
                        exp_q <= exp_q - 1'b1;
                    end
                end
                PACK: begin
                    dout <= zero ? '0 : {sign, exp_final, mant_rnd[MW-1:0]};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fix_to_float.sv
// Testbench for fix_to_float: three instances (truncating signed, rounding
// signed, rounding unsigned) driven with the same stimulus and checked against
// an arithmetic reference model of value, latency and output holding.
module tb_fix_to_float;

    localparam int W    = 16;
    localparam int FW   = 8;
    localparam int EW   = 5;
    localparam int MW   = 10;
    localparam int BIAS = 15;
    localparam int N    = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [W-1:0]  din;
    logic [15:0]   dout_v [N];
    logic          busy_v [N];
    logic          done_v [N];

    bit            cfg_signed [N] = '{1'b1, 1'b1, 1'b0};
    bit            cfg_round  [N] = '{1'b0, 1'b1, 1'b1};

    int            checks = 0;
    int            fails  = 0;

    // Reference model state per instance
    int            cyc = 0;
    bit            check_en = 1'b0;
    bit            active  [N];
    int            acc     [N];
    int            lat     [N];
    logic [15:0]   held    [N];
    logic [15:0]   pending [N];

    fix_to_float #(.IW(8), .FW(8), .EW(5), .MW(10), .SIGNED(1), .ROUND(0)) dut_t (
        .clk(clk), .reset(reset), .start(start), .din(din),
        .dout(dout_v[0]), .busy(busy_v[0]), .done(done_v[0]));

    fix_to_float #(.IW(8), .FW(8), .EW(5), .MW(10), .SIGNED(1), .ROUND(1)) dut_r (
        .clk(clk), .reset(reset), .start(start), .din(din),
        .dout(dout_v[1]), .busy(busy_v[1]), .done(done_v[1]));

    fix_to_float #(.IW(8), .FW(8), .EW(5), .MW(10), .SIGNED(0), .ROUND(1)) dut_u (
        .clk(clk), .reset(reset), .start(start), .din(din),
        .dout(dout_v[2]), .busy(busy_v[2]), .done(done_v[2]));

    always #5 clk = ~clk;

    // Arithmetic reference: value -> {sign, exponent, mantissa}, plus latency.
    function automatic logic [15:0] ref_convert(input logic [15:0] x, input bit sg,
                                                input bit rnd, output int l);
        longint v, mag, mfull, rem, half;
        int     p, e;
        bit     s;
        v   = sg ? longint'($signed(x)) : longint'({48'd0, x});
        s   = (v < 0);
        mag = s ? -v : v;
        if (mag == 0) begin
            l = 2;
            return 16'h0000;
        end
        p = 0;
        for (int b = 0; b < W; b++) if (((mag >> b) & 1) != 0) p = b;
        l = (W - 1 - p) + 3;
        e = p - FW + BIAS;
        if (p >= MW) begin
            mfull = mag >> (p - MW);
            rem   = mag - (mfull << (p - MW));
            half  = (p > MW) ? (longint'(1) << (p - MW - 1)) : 0;
        end else begin
            mfull = mag << (MW - p);
            rem   = 0;
            half  = 0;
        end
        if (rnd && p > MW && (rem > half || (rem == half && (mfull & 1) != 0))) mfull++;
        if (mfull == (longint'(1) << (MW + 1))) begin
            mfull = mfull >> 1;
            e++;
        end
        return {s, 5'(e), 10'(mfull)};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Model update on each rising edge: reset, result publication, acceptance.
    always @(posedge clk) begin
        bit busy_before;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (reset) begin
                active[i] = 1'b0;
                held[i]   = 16'h0000;
                check_en  = 1'b1;
            end else begin
                busy_before = active[i] && ((cyc - 1 - acc[i]) < lat[i]);
                if (active[i] && (cyc - acc[i]) == lat[i]) held[i] = pending[i];
                if (start && !busy_before) begin
                    active[i]  = 1'b1;
                    acc[i]     = cyc;
                    pending[i] = ref_convert(din, cfg_signed[i], cfg_round[i], lat[i]);
                end
            end
        end
    end

    // Compare process: every falling edge, all outputs of all instances.
    always @(negedge clk) begin
        bit exp_busy;
        if (check_en) begin
            for (int i = 0; i < N; i++) begin
                exp_busy = active[i] && ((cyc - acc[i]) < lat[i]);
                checkOutput($sformatf("busy[%0d]@%0d", i, cyc), 32'(busy_v[i]), 32'(exp_busy));
                checkOutput($sformatf("done[%0d]@%0d", i, cyc), 32'(done_v[i]),
                            32'(active[i] && !exp_busy));
                checkOutput($sformatf("dout[%0d]@%0d", i, cyc), 32'(dout_v[i]), 32'(held[i]));
            end
        end
    end

    // One-cycle start pulse; din is scrambled afterwards to expose re-sampling.
    task automatic applyStimulus(input logic [15:0] value);
        @(negedge clk);
        din   = value;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        din   = 16'($urandom);
    endtask

    // Wait until every instance reports done; n counts falling edges since acceptance.
    task automatic waitAllDone(output int n);
        n = 0;
        while (!(done_v[0] && done_v[1] && done_v[2])) begin
            @(negedge clk);
            n++;
            if (n > 60) begin
                checkOutput("done_timeout", 32'(n), 32'd0);
                return;
            end
        end
    endtask

    initial begin
        int n;
        int l;
        logic [15:0] v;

        reset = 1'b1;
        start = 1'b0;
        din   = 16'h0000;

        // Hand-computed values pinning the reference model
        checkOutput("model_0100", 32'(ref_convert(16'h0100, 1, 0, l)), 32'h3C00);
        checkOutput("model_lat_0100", 32'(l), 32'd10);
        checkOutput("model_0000", 32'(ref_convert(16'h0000, 1, 0, l)), 32'h0000);
        checkOutput("model_lat_0000", 32'(l), 32'd2);
        checkOutput("model_8000", 32'(ref_convert(16'h8000, 1, 0, l)), 32'hD800);
        checkOutput("model_FF80", 32'(ref_convert(16'hFF80, 1, 0, l)), 32'hB800);
        checkOutput("model_7FFF_t", 32'(ref_convert(16'h7FFF, 1, 0, l)), 32'h57FF);
        checkOutput("model_7FFF_r", 32'(ref_convert(16'h7FFF, 1, 1, l)), 32'h5800);
        checkOutput("model_FFFF_u", 32'(ref_convert(16'hFFFF, 0, 1, l)), 32'h5C00);

        repeat (2) @(negedge clk);
        reset = 1'b0;
        checkOutput("reset_dout", 32'(dout_v[0]), 32'h0);
        checkOutput("reset_busy", 32'(busy_v[0]), 32'h0);
        checkOutput("reset_done", 32'(done_v[0]), 32'h0);

        // Directed cases with literal expectations
        applyStimulus(16'h0100);
        waitAllDone(n);
        checkOutput("lat_0100", 32'(n), 32'd10);
        checkOutput("dout_0100", 32'(dout_v[0]), 32'h3C00);

        applyStimulus(16'h0000);
        waitAllDone(n);
        checkOutput("lat_0000", 32'(n), 32'd2);
        checkOutput("dout_0000", 32'(dout_v[0]), 32'h0000);

        applyStimulus(16'h8000);
        waitAllDone(n);
        checkOutput("dout_8000", 32'(dout_v[0]), 32'hD800);

        applyStimulus(16'hFF80);
        waitAllDone(n);
        checkOutput("dout_FF80", 32'(dout_v[0]), 32'hB800);

        applyStimulus(16'h7FFF);
        waitAllDone(n);
        checkOutput("dout_7FFF_t", 32'(dout_v[0]), 32'h57FF);
        checkOutput("dout_7FFF_r", 32'(dout_v[1]), 32'h5800);

        applyStimulus(16'hFFFF);
        waitAllDone(n);
        checkOutput("dout_FFFF_u", 32'(dout_v[2]), 32'h5C00);

        // Second start while busy must not disturb the running conversion
        applyStimulus(16'h0100);
        @(negedge clk);
        @(negedge clk);
        din   = 16'h8000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitAllDone(n);
        checkOutput("restart_lat", 32'(n + 3), 32'd10);
        checkOutput("restart_dout", 32'(dout_v[0]), 32'h3C00);

        // Reset in the middle of normalisation
        applyStimulus(16'h0100);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort_done", 32'(done_v[0]), 32'h0);
        checkOutput("abort_busy", 32'(busy_v[0]), 32'h0);
        checkOutput("abort_dout", 32'(dout_v[0]), 32'h0);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        checkOutput("abort_quiet", 32'(done_v[0]), 32'h0);
        applyStimulus(16'h0100);
        waitAllDone(n);
        checkOutput("after_abort", 32'(dout_v[0]), 32'h3C00);

        // Randomised conversions, stray starts and occasional aborts
        for (int t = 0; t < 200; t++) begin
            case ($urandom_range(0, 4))
                0:       v = 16'($urandom);
                1:       v = 16'($urandom) >> $urandom_range(0, 15);
                2:       v = 16'h8000 | (16'($urandom) >> $urandom_range(1, 15));
                3:       v = 16'($urandom_range(0, 3));
                default: v = 16'($urandom) | 16'h00FF;
            endcase
            applyStimulus(v);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                din   = 16'($urandom);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            if ($urandom_range(0, 15) == 0) begin
                repeat ($urandom_range(0, 4)) @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                @(negedge clk);
            end else begin
                waitAllDone(n);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
